rl_ram_1r1w_init: RTL
=====================

// Module: rl_ram_1r1w_init
// PURPOSE
//  Parametrised 1R1W RAM, technology-agnostic successor to the per-vendor 1R1W wrappers.
//  Adds arbitrary (non power-of-2) depth and write-first read/write collision forwarding at byte granularity.
//  Adds a self-clearing sweep after reset or on request, with a busy flag.
//  Used by FIFOs, register files and caches that need defined contents and coherent read-during-write.
// PARAMETERS
//  ABITS      8            address width
//  DBITS      8            data width; any value >=1, last byte lane may be partial
//  DEPTH      2**ABITS     number of words; 2 <= DEPTH <= 2**ABITS
//  INIT_VALUE '0           DBITS-wide value written to every word by the clear sweep
// PORTS
//  clk      in   1               single clock; all logic on rising edge
//  rstn     in   1               asynchronous active-low reset
//  clr      in   1               sync request: restart clear sweep
//  busy     out  1               1 while clear sweep in progress
//  waddr    in   ABITS           write address
//  din      in   DBITS           write data
//  we       in   1               write enable
//  be       in   (DBITS+7)/8     byte enables; be[i] covers din[8i+7:8i]
//  raddr    in   ABITS           read address
//  re       in   1               read enable
//  dout     out  DBITS           read data
//  dout_vld out  1               1 for exactly one cycle per accepted read
// BEHAVIOUR
//  Reset (rstn=0): state=CLEAR, cnt=0, busy=1, dout=0, dout_vld=0, forwarding regs cleared.
//    Array contents are not reset directly; the sweep defines them.
//  FSM states: CLEAR and READY.
//    CLEAR: each cycle write INIT_VALUE (all bytes) to cnt; cnt++.
//           If cnt==DEPTH-1, go to READY next cycle with busy=0; sweep takes exactly DEPTH cycles.
//           User we/re are ignored; dout_vld=0.
//    READY: clr=1 -> CLEAR with cnt=0 next cycle; clr=1 in CLEAR restarts the sweep at cnt=0.
//  Write (READY, we=1, waddr<DEPTH): bytes with be[i]=1 updated at the edge. be=0 is a no-op.
//  Read (READY, re=1, raddr<DEPTH): dout/dout_vld updated one cycle later (latency 1).
//    re=0: dout holds its last value and dout_vld=0.
//  Out of range (addr>=DEPTH): write ignored; read returns dout=INIT_VALUE with dout_vld=1.
//  Collision (we&re, waddr==raddr, same cycle): write-first per byte.
//    dout byte = din byte if be=1, else old stored byte.
//    Implemented with registered din/biten/hit; the array itself is read-first.
//  Write then read of same address in the next cycle: returns new data with no special path.
//  clr and a user access in the same cycle: clr wins; the access is dropped.
//  rstn asserted mid-sweep or mid-read: immediate return to reset values; sweep restarts on release.
// CONFIGURATION
//  RL_RAM_1R1W_INIT_OUTREG_EN defined:
//    extra output register; read latency 2; dout_vld delayed to match.
//    Forwarding and out-of-range data are applied before that register.
//    Reset value of the extra stage is 0.
//  Not defined: latency 1 as above; no extra stage.
// STRUCTURE
//  Package rl_ram_pkg:
//    state_t enum {CLEAR, READY}.
//    Function be2biten(be, DBITS) expanding byte enables to bit enables.
//  Sub-module rl_ram_1r1w_generic:
//    behavioural DEPTH x DBITS array; bit-enabled write; registered read-first output.
//    No reset; the technology-mapping point.
//  Top holds the FSM, sweep counter, write mux (sweep vs user), forwarding and output pipeline.
// TESTING
//  1. Release reset, DEPTH=200, INIT_VALUE=8'hA5:
//     busy=1 for exactly 200 cycles; then read all addresses -> 8'hA5.
//  2. DBITS=12 (partial lane), write 0 to addr 3 with be=2'b11, then write 12'hFFF with be=2'b10:
//     read addr 3 -> 12'hF00.
//  3. Same-cycle we=re, addr 7, old=32'h11223344, din=32'hAABBCCDD, be=4'b0101:
//     dout=32'h11BB33DD next cycle.
//  4. Back-to-back read of addr 5 then addr 6 (holding 8'h01, 8'h02):
//     dout=01,02 on consecutive cycles, dout_vld=1,1, then 0.
//     With the macro: same sequence one cycle later.
//  5. clr pulse after filling memory with 8'h3C:
//     busy=1 for DEPTH cycles, reads return INIT_VALUE.
//     A we during the clr cycle has no effect.
//  6. Assert rstn mid-sweep at cnt=50:
//     busy stays 1; sweep restarts and lasts a full DEPTH cycles after release.
//     raddr=DEPTH (ABITS>log2 DEPTH) -> INIT_VALUE.

Source files
------------

// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the rl_ram family: FSM states, read-source select,
// and byte-enable to bit-enable expansion.
package rl_ram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  // Selects what drives the read data path after an accepted read.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_INIT,
    SRC_RAM
  } rd_src_t;

  localparam int MAX_DBITS = 1024;
  localparam int MAX_LANES = MAX_DBITS / 8;

  // Bit i follows byte lane i/8; bits at or above dbits stay 0.
  function automatic logic [MAX_DBITS-1:0] be2biten(input logic [MAX_LANES-1:0] be,
                                                     input int dbits);
    logic [MAX_DBITS-1:0] biten;
    biten = '0;
    for (int i = 0; i < MAX_DBITS; i++) begin
      if (i < dbits) biten[i] = be[i/8];
    end
    return biten;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w_generic.sv
// Behavioural DEPTH x DBITS 1R1W array: bit-enabled write, registered read-first output.
// This is the technology-mapping point; it carries no reset.
module rl_ram_1r1w_generic #(
  parameter int AW    = 8,
  parameter int DBITS = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [DBITS-1:0] wbiten,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [DEPTH];

  // NOTE: the array and its read register are deliberately left unreset so they map onto
  // RAM macros; the clear sweep in the parent defines the contents instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wbiten) | (wdata & wbiten);
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rl_ram_1r1w_init.sv
// 1R1W RAM with clear sweep after reset / on clr, byte-granular write-first collision
// forwarding and out-of-range reads returning INIT_VALUE. RL_RAM_1R1W_INIT_OUTREG_EN adds
// an output register stage (read latency 2).
module rl_ram_1r1w_init
  import rl_ram_pkg::*;
#(
  parameter int               ABITS      = 8,
  parameter int               DBITS      = 8,
  parameter int               DEPTH      = 2**ABITS,
  parameter logic [DBITS-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  output logic                     busy,
  input  logic [ABITS-1:0]         waddr,
  input  logic [DBITS-1:0]         din,
  input  logic                     we,
  input  logic [(DBITS+7)/8-1:0]   be,
  input  logic [ABITS-1:0]         raddr,
  input  logic                     re,
  output logic [DBITS-1:0]         dout,
  output logic                     dout_vld
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);
  localparam logic [ABITS:0] DEPTH_W = (ABITS+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic             user_ok, w_in, r_in, user_wr, user_rd, rd_in, hit;
  logic [DBITS-1:0] user_biten;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DBITS-1:0] mem_wdata, mem_biten, ram_rdata;

  logic             rd_vld_q, hit_q;
  rd_src_t          rd_src_q;
  logic [DBITS-1:0] fwd_din_q, fwd_biten_q, rd_data;

  // NOTE: combinational blocks assign every output a default first and use blocking '=';
  // this keeps them free of inferred latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // clr takes priority over any user access issued in the same cycle.
  assign user_ok    = (state_q == READY) && !clr;
  assign w_in       = {1'b0, waddr} < DEPTH_W;
  assign r_in       = {1'b0, raddr} < DEPTH_W;
  assign user_wr    = user_ok && we && w_in;
  assign user_rd    = user_ok && re;
  assign rd_in      = user_rd && r_in;
  assign hit        = user_wr && rd_in && (waddr == raddr);
  assign user_biten = DBITS'(be2biten(MAX_LANES'(be), DBITS));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr[AW-1:0];
    mem_wdata = din;
    mem_biten = user_biten;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VALUE;
      mem_biten = '1;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

  rl_ram_1r1w_generic #(
    .AW    (AW),
    .DBITS (DBITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .wbiten (mem_biten),
    .re     (rd_in),
    .raddr  (raddr[AW-1:0]),
    .rdata  (ram_rdata)
  );

  // The array is read-first; collision data is captured here and merged after the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q    <= 1'b0;
      rd_src_q    <= SRC_ZERO;
      hit_q       <= 1'b0;
      fwd_din_q   <= '0;
      fwd_biten_q <= '0;
    end else begin
      rd_vld_q <= user_rd;
      if (user_rd) begin
        rd_src_q    <= r_in ? SRC_RAM : SRC_INIT;
        hit_q       <= hit;
        fwd_din_q   <= din;
        fwd_biten_q <= user_biten;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_src_q)
      SRC_INIT: rd_data = INIT_VALUE;
      SRC_RAM:  rd_data = hit_q ? ((ram_rdata & ~fwd_biten_q) | (fwd_din_q & fwd_biten_q))
                                : ram_rdata;
      default:  rd_data = '0;
    endcase
  end

`ifdef RL_RAM_1R1W_INIT_OUTREG_EN
  logic [DBITS-1:0] dout_q;
  logic             dout_vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= rd_data;
      dout_vld_q <= rd_vld_q;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
`else
  assign dout     = rd_data;
  assign dout_vld = rd_vld_q;
`endif

endmodule
